// File: rtl/escaner_teclado_pkg.sv
// rtl/escaner_teclado_pkg.sv - shared types, key codes and keypad map for the keypad scanner
package escaner_teclado_pkg;

  typedef enum logic [1:0] {
    SIN_TECLA,
    REBOTE,
    PRESIONADA
  } estado_t;

  typedef enum logic [1:0] {
    RES_NINGUNA,
    RES_UNA,
    RES_MULTI
  } resultado_t;

  localparam logic [3:0] TECLA_AST   = 4'hE;
  localparam logic [3:0] TECLA_NUM   = 4'hF;
  localparam int         MAX_DIGITOS = 3;

  // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
    logic [3:0] codigo;
    case ({fila, col})
      4'h0:    codigo = 4'h1;
      4'h1:    codigo = 4'h2;
      4'h2:    codigo = 4'h3;
      4'h3:    codigo = 4'hA;
      4'h4:    codigo = 4'h4;
      4'h5:    codigo = 4'h5;
      4'h6:    codigo = 4'h6;
      4'h7:    codigo = 4'hB;
      4'h8:    codigo = 4'h7;
      4'h9:    codigo = 4'h8;
      4'hA:    codigo = 4'h9;
      4'hB:    codigo = 4'hC;
      4'hC:    codigo = TECLA_AST;
      4'hD:    codigo = 4'h0;
      4'hE:    codigo = TECLA_NUM;
      default: codigo = 4'hD;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/escaner_teclado_if.sv
// rtl/escaner_teclado_if.sv - processor-facing key/number bus of the keypad scanner
interface escaner_teclado_if;
  logic [3:0] Tecla;
  logic       Tecla_Valida;
  logic [7:0] N;
  logic       Dato_Listo;
  logic [9:0] Acumulado;
  logic       Error;

  modport master (
    output Tecla, Tecla_Valida, N, Dato_Listo, Acumulado, Error
  );

  modport slave (
    input Tecla, Tecla_Valida, N, Dato_Listo, Acumulado, Error
  );
endinterface

// File: rtl/escaner_teclado_acumulador.sv
// rtl/escaner_teclado_acumulador.sv - decimal entry: up to 3 digits, '#' delivers N, '*' clears
module acumulador_decimal
  import escaner_teclado_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_tecla,
  input  logic       i_tecla_valida,
  output logic [7:0] o_n,
  output logic       o_dato_listo,
  output logic [9:0] o_acumulado,
  output logic       o_error
);

  logic [7:0] r_n;
  logic       r_dato_listo;
  logic [9:0] r_acum;
  logic [1:0] r_digitos;
  logic       r_error;
  logic [9:0] w_siguiente;

  // At most two digits are held when a third arrives, so 99*10+9 always fits in 10 bits
  assign w_siguiente = r_acum * 10'd10 + {6'd0, i_tecla};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n          <= '0;
      r_dato_listo <= 1'b0;
      r_acum       <= '0;
      r_digitos    <= '0;
      r_error      <= 1'b0;
    end else begin
      r_dato_listo <= 1'b0;
      if (i_tecla_valida) begin
        if (i_tecla <= 4'd9) begin
          if (r_digitos < 2'(MAX_DIGITOS)) begin
            r_acum    <= w_siguiente;
            r_digitos <= r_digitos + 2'd1;
          end
        end else if (i_tecla == TECLA_AST) begin
          r_acum    <= '0;
          r_digitos <= '0;
          r_error   <= 1'b0;
        end else if (i_tecla == TECLA_NUM && r_digitos != 2'd0) begin
          if (r_acum <= 10'd255) begin
            r_n          <= r_acum[7:0];
            r_dato_listo <= 1'b1;
            r_error      <= 1'b0;
          end else begin
            r_error <= 1'b1;
          end
          r_acum    <= '0;
          r_digitos <= '0;
        end
      end
    end
  end

  assign o_n          = r_n;
  assign o_dato_listo = r_dato_listo;
  assign o_acumulado  = r_acum;
  assign o_error      = r_error;

endmodule

// File: rtl/escaner_teclado.sv
// rtl/escaner_teclado.sv - 4x4 keypad scanner, debounce FSM and decimal entry
// Build option ESCANER_REPETICION_EN adds auto-repeat of a held key every REPEAT_SCANS scans.
module escaner_teclado
  import escaner_teclado_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 25
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Columnas,
  output logic [3:0] Filas,
  escaner_teclado_if.master bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_parametro_invalido
  end

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sinc;
  logic [CNT_W-1:0] r_cnt_div;
  logic [1:0]       r_fila;
  logic             r_hay_tecla;
  logic             r_multi;
  logic [3:0]       r_codigo_scan;

  logic             w_muestra;
  logic             w_fin_scan;
  logic [3:0]       w_pulsadas;
  logic             w_fila_hay;
  logic             w_una_col;
  logic [1:0]       w_col_idx;
  logic             w_hay_total;
  logic             w_multi_total;
  logic [3:0]       w_codigo_total;
  resultado_t       w_resultado;

  assign w_muestra  = (r_cnt_div == CNT_W'(SCAN_DIV - 1));
  assign w_fin_scan = w_muestra && (r_fila == 2'd3);
  assign w_pulsadas = ~r_col_sinc;
  assign w_fila_hay = |w_pulsadas;
  assign w_una_col  = w_fila_hay && ((w_pulsadas & (w_pulsadas - 4'd1)) == 4'd0);

  always_comb begin
    w_col_idx = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (w_pulsadas[c]) w_col_idx = 2'(c);
    end
  end

  // Combine the row being sampled with what earlier rows of this scan already saw
  assign w_hay_total    = r_hay_tecla | w_fila_hay;
  assign w_multi_total  = r_multi | (w_fila_hay & (!w_una_col | r_hay_tecla));
  assign w_codigo_total = w_fila_hay ? codigo_tecla(r_fila, w_col_idx) : r_codigo_scan;
  assign w_resultado    = w_multi_total ? RES_MULTI : (w_hay_total ? RES_UNA : RES_NINGUNA);

  assign Filas = ~(4'b0001 << r_fila);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_col_meta    <= 4'hF;
      r_col_sinc    <= 4'hF;
      r_cnt_div     <= '0;
      r_fila        <= '0;
      r_hay_tecla   <= 1'b0;
      r_multi       <= 1'b0;
      r_codigo_scan <= '0;
    end else begin
      r_col_meta <= Columnas;
      r_col_sinc <= r_col_meta;
      if (w_muestra) begin
        r_cnt_div <= '0;
        r_fila    <= r_fila + 2'd1;
        if (w_fin_scan) begin
          r_hay_tecla   <= 1'b0;
          r_multi       <= 1'b0;
          r_codigo_scan <= '0;
        end else begin
          r_hay_tecla   <= w_hay_total;
          r_multi       <= w_multi_total;
          r_codigo_scan <= w_codigo_total;
        end
      end else begin
        r_cnt_div <= r_cnt_div + 1'b1;
      end
    end
  end

  estado_t          r_estado, w_estado_sig;
  logic [3:0]       r_cand, w_cand_sig;
  logic [DEB_W-1:0] r_deb_cnt, w_deb_sig;
  logic [3:0]       r_tecla, w_tecla_sig;
  logic             r_valida, w_valida_sig;
  logic [DEB_W-1:0] w_deb_inc;

  assign w_deb_inc = r_deb_cnt + 1'b1;

`ifdef ESCANER_REPETICION_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] r_rep_cnt, w_rep_sig;
  logic [REP_W-1:0] w_rep_inc;
  assign w_rep_inc = r_rep_cnt + 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_estado  <= SIN_TECLA;
      r_cand    <= '0;
      r_deb_cnt <= '0;
      r_tecla   <= '0;
      r_valida  <= 1'b0;
`ifdef ESCANER_REPETICION_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_estado  <= w_estado_sig;
      r_cand    <= w_cand_sig;
      r_deb_cnt <= w_deb_sig;
      r_tecla   <= w_tecla_sig;
      r_valida  <= w_valida_sig;
`ifdef ESCANER_REPETICION_EN
      r_rep_cnt <= w_rep_sig;
`endif
    end
  end

  // r_deb_cnt counts matching presses in REBOTE and empty scans in PRESIONADA
  always_comb begin
    w_estado_sig = r_estado;
    w_cand_sig   = r_cand;
    w_deb_sig    = r_deb_cnt;
    w_tecla_sig  = r_tecla;
    w_valida_sig = 1'b0;
`ifdef ESCANER_REPETICION_EN
    w_rep_sig    = r_rep_cnt;
`endif
    if (w_fin_scan) begin
      case (r_estado)
        SIN_TECLA: begin
          if (w_resultado == RES_UNA) begin
            w_cand_sig = w_codigo_total;
            if (DEBOUNCE_SCANS == 1) begin
              w_estado_sig = PRESIONADA;
              w_tecla_sig  = w_codigo_total;
              w_valida_sig = 1'b1;
              w_deb_sig    = '0;
`ifdef ESCANER_REPETICION_EN
              w_rep_sig    = '0;
`endif
            end else begin
              w_estado_sig = REBOTE;
              w_deb_sig    = DEB_W'(1);
            end
          end
        end
        REBOTE: begin
          if (w_resultado == RES_UNA && w_codigo_total == r_cand) begin
            if (w_deb_inc == DEB_W'(DEBOUNCE_SCANS)) begin
              w_estado_sig = PRESIONADA;
              w_tecla_sig  = r_cand;
              w_valida_sig = 1'b1;
              w_deb_sig    = '0;
`ifdef ESCANER_REPETICION_EN
              w_rep_sig    = '0;
`endif
            end else begin
              w_deb_sig = w_deb_inc;
            end
          end else begin
            w_estado_sig = SIN_TECLA;
            w_deb_sig    = '0;
          end
        end
        PRESIONADA: begin
          if (w_resultado != RES_UNA) begin
            if (w_deb_inc == DEB_W'(DEBOUNCE_SCANS)) begin
              w_estado_sig = SIN_TECLA;
              w_deb_sig    = '0;
            end else begin
              w_deb_sig = w_deb_inc;
            end
          end else begin
            w_deb_sig = '0;
          end
`ifdef ESCANER_REPETICION_EN
          if (w_resultado == RES_UNA && w_codigo_total == r_cand) begin
            if (w_rep_inc == REP_W'(REPEAT_SCANS)) begin
              w_valida_sig = 1'b1;
              w_rep_sig    = '0;
            end else begin
              w_rep_sig = w_rep_inc;
            end
          end else begin
            w_rep_sig = '0;
          end
`endif
        end
        default: w_estado_sig = SIN_TECLA;
      endcase
    end
  end

  assign bus.Tecla        = r_tecla;
  assign bus.Tecla_Valida = r_valida;

  acumulador_decimal u_acumulador (
    .i_clk          (Clk),
    .i_rst          (Reset),
    .i_tecla        (r_tecla),
    .i_tecla_valida (r_valida),
    .o_n            (bus.N),
    .o_dato_listo   (bus.Dato_Listo),
    .o_acumulado    (bus.Acumulado),
    .o_error        (bus.Error)
  );

endmodule

// File: tb/tb_escaner_teclado.sv
// tb/tb_escaner_teclado.sv - scoreboard bench: keypad model, expected key/number queues
module tb_escaner_teclado;

  localparam int SCAN = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Columnas;
  logic [3:0]  Filas;
  logic [15:0] teclas = '0;
  logic [3:0]  fase;
  logic [3:0]  fila_esp;
  int          errores = 0;
  int          total = 0;
  int          q_tecla[$];
  int          q_n[$];
  int          pos_de[16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11, 15, 12, 14};

  escaner_teclado_if bus_if ();

  escaner_teclado #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2),
    .REPEAT_SCANS   (3)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Columnas (Columnas),
    .Filas    (Filas),
    .bus      (bus_if)
  );

  always #5 Clk = ~Clk;

  // Expected scan position: a full scan ends every 16 clocks after reset release
  always @(posedge Clk) fase <= Reset ? 4'd0 : fase + 4'd1;

  always_comb begin
    Columnas = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!Filas[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (teclas[r*4+c]) Columnas[c] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nombre, input int act, input int esp);
    total++;
    if (act !== esp) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d", nombre, act, esp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (fase[1:0] == 2'd0) begin
        fila_esp = ~(4'b0001 << fase[3:2]);
        chk("filas", int'(Filas), int'(fila_esp));
      end
      if (bus_if.Tecla_Valida) begin
        chk("latencia_tecla", int'(fase), 0);
        if (q_tecla.size() == 0) chk("tecla_inesperada", int'(bus_if.Tecla), -1);
        else chk("tecla", int'(bus_if.Tecla), q_tecla.pop_front());
      end
      if (bus_if.Dato_Listo) begin
        chk("latencia_dato", int'(fase), 1);
        if (q_n.size() == 0) chk("dato_inesperado", int'(bus_if.N), -1);
        else chk("n", int'(bus_if.N), q_n.pop_front());
      end
    end
  end

  task automatic alinear();
    for (int i = 0; i < SCAN && fase != 4'd0; i++) @(negedge Clk);
  endtask

  task automatic pulsar(input int cod, input int on_s, input int off_s);
    alinear();
    teclas[pos_de[cod]] = 1'b1;
    repeat (on_s * SCAN) @(negedge Clk);
    teclas[pos_de[cod]] = 1'b0;
    repeat (off_s * SCAN) @(negedge Clk);
  endtask

  task automatic tecla(input int cod);
    q_tecla.push_back(cod);
    pulsar(cod, 3, 3);
  endtask

  task automatic pareja(input int a, input int b);
    alinear();
    teclas[pos_de[a]] = 1'b1;
    teclas[pos_de[b]] = 1'b1;
    repeat (3 * SCAN) @(negedge Clk);
    teclas = '0;
    repeat (3 * SCAN) @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_filas", int'(Filas), 14);
    chk("rst_tecla", int'(bus_if.Tecla), 0);
    chk("rst_valida", int'(bus_if.Tecla_Valida), 0);
    chk("rst_n", int'(bus_if.N), 0);
    chk("rst_dato", int'(bus_if.Dato_Listo), 0);
    chk("rst_acum", int'(bus_if.Acumulado), 0);
    chk("rst_error", int'(bus_if.Error), 0);
    Reset = 1'b0;

    q_tecla.push_back(5);
    pulsar(5, 4, 3);
    chk("t1_acum", int'(bus_if.Acumulado), 5);

    pulsar(5, 1, 1);
    pulsar(5, 1, 3);
    chk("t2_acum", int'(bus_if.Acumulado), 5);
    tecla(14);
    chk("ast_acum", int'(bus_if.Acumulado), 0);

    tecla(1);  chk("t3_acum1", int'(bus_if.Acumulado), 1);
    tecla(2);  chk("t3_acum12", int'(bus_if.Acumulado), 12);
    tecla(8);  chk("t3_acum128", int'(bus_if.Acumulado), 128);
    q_n.push_back(128);
    tecla(15);
    chk("t3_n", int'(bus_if.N), 128);
    chk("t3_error", int'(bus_if.Error), 0);
    chk("t3_acum", int'(bus_if.Acumulado), 0);

    tecla(3); tecla(0); tecla(0);
    chk("t4_acum300", int'(bus_if.Acumulado), 300);
    tecla(15);
    chk("t4_error", int'(bus_if.Error), 1);
    chk("t4_n", int'(bus_if.N), 128);
    chk("t4_acum", int'(bus_if.Acumulado), 0);
    tecla(14);
    chk("t4_error_clr", int'(bus_if.Error), 0);

    pareja(1, 2);
    pareja(1, 4);
    chk("t5_multi_acum", int'(bus_if.Acumulado), 0);
    tecla(1); tecla(2); tecla(3);
    chk("t5_acum123", int'(bus_if.Acumulado), 123);
    tecla(4);
    chk("t5_cuarto", int'(bus_if.Acumulado), 123);
    q_n.push_back(123);
    tecla(15);
    chk("t5_n", int'(bus_if.N), 123);

    tecla(2); tecla(5); tecla(5);
    q_n.push_back(255);
    tecla(15);
    chk("lim_n255", int'(bus_if.N), 255);
    chk("lim_err255", int'(bus_if.Error), 0);
    tecla(2); tecla(5); tecla(6);
    tecla(15);
    chk("lim_err256", int'(bus_if.Error), 1);
    chk("lim_n256", int'(bus_if.N), 255);
    tecla(15);
    chk("hash_vacio_err", int'(bus_if.Error), 1);
    tecla(7); tecla(10);
    chk("letra_acum", int'(bus_if.Acumulado), 7);

    alinear();
    teclas[pos_de[9]] = 1'b1;
    repeat (SCAN) @(negedge Clk);
    Reset = 1'b1;
    teclas = '0;
    repeat (3) @(negedge Clk);
    chk("t6_filas", int'(Filas), 14);
    chk("t6_tecla", int'(bus_if.Tecla), 0);
    chk("t6_n", int'(bus_if.N), 0);
    chk("t6_error", int'(bus_if.Error), 0);
    chk("t6_acum", int'(bus_if.Acumulado), 0);
    Reset = 1'b0;
    repeat (3 * SCAN) @(negedge Clk);

`ifdef ESCANER_REPETICION_EN
    q_tecla.push_back(7); q_tecla.push_back(7); q_tecla.push_back(7);
    pulsar(7, 10, 3);
    chk("t6_repite", int'(bus_if.Acumulado), 777);
`else
    q_tecla.push_back(7);
    pulsar(7, 10, 3);
    chk("t6_repite", int'(bus_if.Acumulado), 7);
`endif

    chk("cola_tecla", q_tecla.size(), 0);
    chk("cola_n", q_n.size(), 0);
    $display("Result: errors=%0d of %0d checks", errores, total);
    $finish;
  end

endmodule
